// File: rtl/sysid_regs.sv
// rtl/sysid_regs.sv - Avalon-MM system ID, build timestamp, uptime counter and scratch register slave
module sysid_regs #(
    parameter logic [31:0] ID_VALUE     = 32'h5139_0A40,
    parameter logic [31:0] TIMESTAMP    = 32'h0,
    parameter int          NUM_SCRATCH  = 4,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [3:0] ADDR_ID      = 4'd0;
    localparam logic [3:0] ADDR_TS      = 4'd1;
    localparam logic [3:0] ADDR_UP_LO   = 4'd2;
    localparam logic [3:0] ADDR_UP_HI   = 4'd3;
    localparam logic [3:0] ADDR_CONTROL = 4'd4;

    logic [63:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic        en_q, en_d;
    logic        lock_q, lock_d;
    logic [31:0] scr_q [NUM_SCRATCH];
    logic [31:0] scr_d [NUM_SCRATCH];
    logic        pv_q [READ_LATENCY];
    logic        pv_d [READ_LATENCY];
    logic [31:0] pd_q [READ_LATENCY];
    logic [31:0] pd_d [READ_LATENCY];

    logic        rd_acc;
    logic        ctrl_wr;
    logic        clr;
    logic [31:0] rd_data;

    always_comb begin
        // A simultaneous write wins; the read is dropped entirely.
        rd_acc  = read & ~write;
        ctrl_wr = write && (address == ADDR_CONTROL);
        clr     = ctrl_wr && byteenable[0] && writedata[1];

        rd_data = '0;
        case (address)
            ADDR_ID:      rd_data = ID_VALUE;
            ADDR_TS:      rd_data = TIMESTAMP;
            ADDR_UP_LO:   rd_data = cnt_q[31:0];
            ADDR_UP_HI:   rd_data = hi_q;
            ADDR_CONTROL: rd_data = {23'b0, lock_q, 7'b0, en_q};
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (address == 4'(8 + i)) rd_data = scr_q[i];
                end
            end
        endcase

        if (clr)       cnt_d = '0;
        else if (en_q) cnt_d = cnt_q + 64'd1;
        else           cnt_d = cnt_q;

        // High half is latched on the same edge the low half is returned.
        hi_d = (rd_acc && address == ADDR_UP_LO) ? cnt_q[63:32] : hi_q;

        en_d   = en_q;
        lock_d = lock_q;
        if (ctrl_wr) begin
            if (byteenable[0]) en_d = writedata[0];
            if (byteenable[1] && writedata[8]) lock_d = 1'b1;
        end

        for (int i = 0; i < NUM_SCRATCH; i++) begin
            scr_d[i] = scr_q[i];
            if (write && !lock_q && address == 4'(8 + i)) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteenable[b]) scr_d[i][8*b +: 8] = writedata[8*b +: 8];
                end
            end
        end

        // Data is zeroed in empty slots so readdata is 0 whenever not valid.
        pv_d[0] = rd_acc;
        pd_d[0] = rd_acc ? rd_data : 32'h0;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pd_d[i] = pd_q[i-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            en_q   <= 1'b1;
            lock_q <= 1'b0;
            for (int i = 0; i < NUM_SCRATCH; i++) scr_q[i] <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pv_q[i] <= 1'b0;
                pd_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            en_q   <= en_d;
            lock_q <= lock_d;
            for (int i = 0; i < NUM_SCRATCH; i++) scr_q[i] <= scr_d[i];
            for (int i = 0; i < READ_LATENCY; i++) begin
                pv_q[i] <= pv_d[i];
                pd_q[i] <= pd_d[i];
            end
        end
    end

    assign readdata      = pd_q[READ_LATENCY-1];
    assign readdatavalid = pv_q[READ_LATENCY-1];

endmodule
